universal_shift_reg_sync_reset: RTL and testbench
=================================================

// Module: universal_shift_reg_sync_reset
// PURPOSE
//  Parametrised successor to the single-bit sync-reset D flip-flop.
//  WIDTH-bit universal register: hold, shift right, shift left or parallel load.
//  Provides serial in/out on both ends, registered q and combinational q_not.
//  Adds a shift counter with a one-cycle "done" pulse after WIDTH shifts.
//  Building block for serialisers and deserialisers in the lab designs.
// PARAMETERS
//  WIDTH        8              register width in bits (>= 2)
//  RESET_VALUE  {WIDTH{1'b0}}  value loaded into q on reset
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  en         in   1      clock enable; 0 = hold all state
//  mode       in   2      00 hold, 01 shift right, 10 shift left, 11 load d
//  d          in   WIDTH  parallel load data
//  ser_in_r   in   1      bit entering q[WIDTH-1] on shift right
//  ser_in_l   in   1      bit entering q[0] on shift left
//  rot        in   1      rotate request; used only when ROTATE_EN is defined
//  q          out  WIDTH  register contents
//  q_not      out  WIDTH  ~q, combinational
//  ser_out_r  out  1      q[0], combinational
//  ser_out_l  out  1      q[WIDTH-1], combinational
//  done       out  1      registered one-cycle pulse: WIDTH shifts since last load
// BEHAVIOUR
//  - Reset (sampled at clk edge): q=RESET_VALUE, shift_cnt=0, done=0.
//    q_not=~RESET_VALUE. Reset overrides en and mode.
//  - en=0: q and shift_cnt hold; done=0 on the next edge.
//  - en=1, mode=00: q holds, shift_cnt holds, done=0.
//  - en=1, mode=01: q <= {ser_in_r, q[WIDTH-1:1]}.
//  - en=1, mode=10: q <= {q[WIDTH-2:0], ser_in_l}.
//  - en=1, mode=11: q <= d; shift_cnt <= 0; done <= 0.
//  - Latency: q updates one edge after the inputs are sampled.
//  - shift_cnt is internal, $clog2(WIDTH+1) bits.
//    +1 on each enabled shift (01 or 10); saturates at WIDTH.
//    Mixing directions still counts each shift.
//  - done <= 1 only on the edge where shift_cnt goes WIDTH-1 -> WIDTH.
//    Otherwise done <= 0.
//    At saturation, further shifts give no new pulse until the next load.
//  - Reset mid-shift sequence: count is discarded.
//    A new pulse needs a reset or load, then WIDTH shifts.
// CONFIGURATION
//  ROTATE_EN defined:
//    - rot=1 on shift right: the entering bit is q[0] (ser_in_r ignored).
//    - rot=1 on shift left: the entering bit is q[WIDTH-1] (ser_in_l ignored).
//    - Rotates count as shifts.
//  ROTATE_EN undefined: rot is ignored; serial inputs are always used.
// TESTING  (WIDTH=8, RESET_VALUE=8'h00, clk period 1us)
//  1 reset=1 for 2 edges with en=1, mode=11, d=8'hFF.
//    -> q=8'h00, q_not=8'hFF, done=0.
//  2 load d=8'hA5, then 1 shift right, ser_in_r=1.
//    -> q=8'hD2; ser_out_r=0.
//  3 load d=8'h81, then 1 shift left, ser_in_l=0.
//    -> q=8'h02; ser_out_l=0.
//  4 load 8'h00, then 8 shifts right with ser_in_r=1.
//    -> q=8'hFF; done high exactly one cycle after the 8th edge.
//    -> a 9th shift gives no done pulse.
//  5 en=0 with mode=01 for 3 cycles, then reset=1 together with mode=11.
//    -> q unchanged while en=0; q=8'h00 after reset (reset wins).
//  6 ROTATE_EN: load 8'h01, rot=1, one shift right with ser_in_r=0.
//    -> q=8'h80.
//    Without ROTATE_EN, same stimulus -> q=8'h00.

Source files
------------

// File: rtl/universal_shift_reg_sync_reset_if.sv
// Signal bundle for the universal shift register.
// Master drives controls/data; slave is the register.
interface universal_shift_reg_sync_reset_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             ser_in_r;
    logic             ser_in_l;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_not;
    logic             ser_out_r;
    logic             ser_out_l;
    logic             done;

    modport master (
        output en, mode, d, ser_in_r, ser_in_l, rot,
        input  q, q_not, ser_out_r, ser_out_l, done
    );

    modport slave (
        input  en, mode, d, ser_in_r, ser_in_l, rot,
        output q, q_not, ser_out_r, ser_out_l, done
    );
endinterface

// File: rtl/universal_shift_reg_sync_reset.sv
// WIDTH-bit universal register: hold, shift R/L, load, done pulse after WIDTH shifts.
// Optional feature macro: ROTATE_EN (rot selects end-around feedback).
module universal_shift_reg_sync_reset #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic clk,
    input logic reset,
    universal_shift_reg_sync_reset_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;
    localparam logic [1:0] M_LOAD  = 2'b11;

    logic [WIDTH-1:0] q;
    logic [CW-1:0]    shift_cnt;
    logic             done;
    logic             in_r;
    logic             in_l;
    logic             shifting;

`ifdef ROTATE_EN
    assign in_r = bus.rot ? q[0] : bus.ser_in_r;
    assign in_l = bus.rot ? q[WIDTH-1] : bus.ser_in_l;
`else
    logic unused_rot;
    assign unused_rot = bus.rot;
    assign in_r = bus.ser_in_r;
    assign in_l = bus.ser_in_l;
`endif

    assign shifting = bus.en &&
                      (bus.mode == M_RIGHT || bus.mode == M_LEFT);

    // Data path: reset, then mode-selected update when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (bus.en) begin
            unique case (bus.mode)
                M_HOLD:  q <= q;
                M_RIGHT: q <= {in_r, q[WIDTH-1:1]};
                M_LEFT:  q <= {q[WIDTH-2:0], in_l};
                M_LOAD:  q <= bus.d;
                default: q <= q;
            endcase
        end
    end

    // Saturating shift counter; cleared by load, pulse on reaching WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= shifting && (shift_cnt == CW'(WIDTH - 1));
            if (bus.en && bus.mode == M_LOAD) begin
                shift_cnt <= '0;
            end else if (shifting && shift_cnt != CW'(WIDTH)) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
        end
    end

    assign bus.q         = q;
    assign bus.q_not     = ~q;
    assign bus.ser_out_r = q[0];
    assign bus.ser_out_l = q[WIDTH-1];
    assign bus.done      = done;
endmodule

// File: tb/tb_universal_shift_reg_sync_reset.sv
// Directed self-checking bench for universal_shift_reg_sync_reset (WIDTH=8).
// Rotate expectations follow the ROTATE_EN macro.
`timescale 1ns/1ps
module tb_universal_shift_reg_sync_reset;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    universal_shift_reg_sync_reset_if #(.WIDTH(8)) bus ();

    universal_shift_reg_sync_reset #(
        .WIDTH(8),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #500 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        bus.en   = 1'b1;
        bus.mode = 2'b11;
        bus.d    = v;
        step();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.en   = 1'b1;
        bus.mode = 2'b11;
        bus.d    = 8'hFF;
        step();
        step();
        chk8("reset_q", bus.q, 8'h00);
        chk8("reset_q_not", bus.q_not, 8'hFF);
        chk8("reset_done", {7'd0, bus.done}, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_shift_right();
        load(8'hA5);
        chk8("load_a5", bus.q, 8'hA5);
        chk8("load_a5_q_not", bus.q_not, 8'h5A);
        bus.mode     = 2'b01;
        bus.ser_in_r = 1'b1;
        step();
        chk8("shr_q", bus.q, 8'hD2);
        chk8("shr_ser_out_r", {7'd0, bus.ser_out_r}, 8'h00);
        chk8("shr_ser_out_l", {7'd0, bus.ser_out_l}, 8'h01);
        bus.mode = 2'b00;
        step();
        chk8("hold_q", bus.q, 8'hD2);
    endtask

    task automatic test_shift_left();
        load(8'h81);
        bus.mode     = 2'b10;
        bus.ser_in_l = 1'b0;
        step();
        chk8("shl_q", bus.q, 8'h02);
        chk8("shl_ser_out_l", {7'd0, bus.ser_out_l}, 8'h00);
        bus.ser_in_l = 1'b1;
        step();
        chk8("shl_in1_q", bus.q, 8'h05);
    endtask

    task automatic test_done();
        logic [7:0] exp_q;
        load(8'h00);
        bus.mode     = 2'b01;
        bus.ser_in_r = 1'b1;
        exp_q = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_q = {1'b1, exp_q[7:1]};
            chk8($sformatf("done_q_%0d", i), bus.q, exp_q);
            chk8($sformatf("done_pulse_%0d", i), {7'd0, bus.done},
                 (i == 8) ? 8'h01 : 8'h00);
        end
        step();
        chk8("done_9th_q", bus.q, 8'hFF);
        chk8("done_9th_pulse", {7'd0, bus.done}, 8'h00);
    endtask

    task automatic test_mixed_and_reload();
        load(8'h00);
        for (int i = 1; i <= 8; i++) begin
            bus.mode = (i % 2 == 1) ? 2'b10 : 2'b01;
            step();
            chk8($sformatf("mix_pulse_%0d", i), {7'd0, bus.done},
                 (i == 8) ? 8'h01 : 8'h00);
        end
        bus.mode = 2'b00;
        step();
        chk8("mix_hold_done", {7'd0, bus.done}, 8'h00);
    endtask

    task automatic test_en_hold_reset();
        load(8'h3C);
        bus.en   = 1'b0;
        bus.mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk8($sformatf("en0_q_%0d", i), bus.q, 8'h3C);
        end
        reset    = 1'b1;
        bus.en   = 1'b1;
        bus.mode = 2'b11;
        bus.d    = 8'hFF;
        step();
        chk8("reset_wins_q", bus.q, 8'h00);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_seq();
        load(8'h00);
        bus.mode = 2'b10;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        bus.en   = 1'b1;
        bus.mode = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk8($sformatf("midrst_pulse_%0d", i), {7'd0, bus.done},
                 (i == 8) ? 8'h01 : 8'h00);
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_r;
        logic [7:0] exp_l;
`ifdef ROTATE_EN
        exp_r = 8'h80;
        exp_l = 8'h01;
`else
        exp_r = 8'h00;
        exp_l = 8'h00;
`endif
        load(8'h01);
        bus.rot      = 1'b1;
        bus.mode     = 2'b01;
        bus.ser_in_r = 1'b0;
        step();
        chk8("rot_right_q", bus.q, exp_r);
        bus.rot = 1'b0;
        load(8'h80);
        bus.rot      = 1'b1;
        bus.mode     = 2'b10;
        bus.ser_in_l = 1'b0;
        step();
        chk8("rot_left_q", bus.q, exp_l);
        bus.rot = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.mode     = 2'b00;
        bus.d        = 8'h00;
        bus.ser_in_r = 1'b0;
        bus.ser_in_l = 1'b0;
        bus.rot      = 1'b0;
        test_reset();
        test_shift_right();
        test_shift_left();
        test_done();
        test_mixed_and_reload();
        test_en_hold_reset();
        test_reset_mid_seq();
        test_rotate();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
